// File: rtl/cpu_run_controller.sv
// Run controller: resets the CPU, runs it under a cycle budget, then streams out a state dump.
// Define RUN_CTRL_MEM_DUMP_EN to append the memory dump after the register-file dump.
module cpu_run_controller #(
  parameter int DATA_WIDTH     = 16,
  parameter int ADDR_WIDTH     = 8,
  parameter int CNT_WIDTH      = 16,
  parameter int RESET_CYCLES   = 2,
  parameter int REG_COUNT      = 8,
  parameter int MEM_DUMP_DEPTH = 15
) (
  input  logic                  clk_i,
  input  logic                  reset_ni,
  input  logic                  start_i,
  input  logic                  abort_i,
  input  logic [CNT_WIDTH-1:0]  cycles_i,
  input  logic                  cpu_halt_i,
  output logic                  cpu_reset_no,
  output logic                  cpu_en_o,
  output logic                  dump_req_o,
  output logic                  dump_sel_o,
  output logic [ADDR_WIDTH-1:0] dump_addr_o,
  input  logic                  dump_ack_i,
  input  logic [DATA_WIDTH-1:0] dump_data_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [DATA_WIDTH-1:0] out_data_o,
  output logic                  out_last_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [1:0]            status_o,
  output logic [CNT_WIDTH-1:0]  cycle_count_o
);

  localparam int RST_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [RST_W-1:0]      RST_LAST = RST_W'(RESET_CYCLES - 1);
  localparam logic [ADDR_WIDTH-1:0] REG_LAST = ADDR_WIDTH'(REG_COUNT - 1);
  localparam logic [ADDR_WIDTH-1:0] MEM_LAST = ADDR_WIDTH'(MEM_DUMP_DEPTH - 1);
`ifdef RUN_CTRL_MEM_DUMP_EN
  localparam bit MEM_EN = 1'b1;
`else
  localparam bit MEM_EN = 1'b0;
`endif

  typedef enum logic [2:0] {IDLE, RESET, RUN, DUMP_REG, DUMP_MEM, DONE} state_t;

  state_t                state, state_next, dump_first;
  logic [CNT_WIDTH-1:0]  budget, count, count_inc;
  logic [1:0]            status;
  logic [RST_W-1:0]      rst_cnt;
  logic                  req, valid, last;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] data;
  logic                  active, abort_act, run_stop, ack_take, xfer, final_word;

  always_comb begin
    state_next = state;
    dump_first = DONE;
    if (REG_COUNT > 0)
      dump_first = DUMP_REG;
    else if (MEM_EN)
      dump_first = DUMP_MEM;
    count_inc  = (count == '1) ? count : count + 1'b1;
    active     = (state == RESET) || (state == RUN) || (state == DUMP_REG) || (state == DUMP_MEM);
    abort_act  = active && abort_i;
    // The budget compare uses the post-increment count so a budget of B gives exactly B RUN cycles.
    run_stop   = (state == RUN) && (cpu_halt_i || ((budget != '0) && (count_inc == budget)));
    ack_take   = req && dump_ack_i;
    xfer       = valid && out_ready_i;
    final_word = (state == DUMP_MEM) ? (addr == MEM_LAST) : ((addr == REG_LAST) && !MEM_EN);
    case (state)
      IDLE, DONE: if (start_i) state_next = RESET;
      RESET:      if (rst_cnt == RST_LAST) state_next = RUN;
      RUN:        if (run_stop) state_next = dump_first;
      DUMP_REG:   if (xfer && (addr == REG_LAST)) state_next = MEM_EN ? DUMP_MEM : DONE;
      DUMP_MEM:   if (xfer && (addr == MEM_LAST)) state_next = DONE;
      default:    state_next = IDLE;
    endcase
    if (abort_act)
      state_next = DONE;
  end

  always_ff @(posedge clk_i) begin
    if (!reset_ni)
      state <= IDLE;
    else
      state <= state_next;
  end

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      budget  <= '0;
      count   <= '0;
      status  <= 2'b00;
      rst_cnt <= '0;
      req     <= 1'b0;
      valid   <= 1'b0;
      last    <= 1'b0;
      addr    <= '0;
      data    <= '0;
    end else begin
      if (state == RESET)
        rst_cnt <= rst_cnt + 1'b1;
      else
        rst_cnt <= '0;
      if (((state == IDLE) || (state == DONE)) && start_i) begin
        budget <= cycles_i;
        count  <= '0;
        status <= 2'b00;
        addr   <= '0;
      end
      if (state == RUN)
        count <= count_inc;
      if (abort_act) begin
        status <= 2'b11;
        req    <= 1'b0;
        valid  <= 1'b0;
        last   <= 1'b0;
      end else begin
        if (run_stop) begin
          status <= cpu_halt_i ? 2'b01 : 2'b10;
          addr   <= '0;
          req    <= (dump_first != DONE);
        end
        // req and valid are never high together, so capture and transfer cannot collide.
        if (ack_take) begin
          data  <= dump_data_i;
          req   <= 1'b0;
          valid <= 1'b1;
          last  <= final_word;
        end
        if (xfer) begin
          valid <= 1'b0;
          last  <= 1'b0;
          if (!last) begin
            req  <= 1'b1;
            addr <= ((state == DUMP_REG) && (addr == REG_LAST)) ? '0 : addr + 1'b1;
          end
        end
      end
    end
  end

  assign cpu_reset_no  = (state != RESET);
  assign cpu_en_o      = (state == RUN);
  assign dump_req_o    = req;
  assign dump_addr_o   = addr;
  assign out_valid_o   = valid;
  assign out_data_o    = data;
  assign out_last_o    = last;
  assign busy_o        = active;
  assign done_o        = (state == DONE);
  assign status_o      = status;
  assign cycle_count_o = count;
`ifdef RUN_CTRL_MEM_DUMP_EN
  assign dump_sel_o    = (state == DUMP_MEM);
`else
  assign dump_sel_o    = 1'b0;
`endif

endmodule

// File: doc/cpu_run_controller.md
CPU_RUN_CONTROLLER -- requirements
Module: cpu_run_controller

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, CPU data / dump word width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 8, dump address width.
REQ-003 SHALL have parameter CNT_WIDTH, default 16, cycle counter / budget width.
REQ-004 SHALL have parameter RESET_CYCLES, default 2, CPU reset length in clocks (>=1).
REQ-005 SHALL have parameter REG_COUNT, default 8, register-file words dumped.
REQ-006 SHALL have parameter MEM_DUMP_DEPTH, default 15, memory words dumped (>=1).
REQ-007 SHALL have ports, in order:
  clk_i  in  1  single clock, all logic on rising edge
  reset_ni  in  1  synchronous active-low reset
  start_i  in  1  begin a run (single-cycle pulse or level)
  abort_i  in  1  abandon the current run
  cycles_i  in  CNT_WIDTH  cycle budget, latched on accepted start; 0 = unlimited
  cpu_halt_i  in  1  CPU halt indication
  cpu_reset_no  out  1  active-low reset to CPU
  cpu_en_o  out  1  CPU clock enable
  dump_req_o  out  1  dump read request
  dump_sel_o  out  1  0 = register file, 1 = memory
  dump_addr_o  out  ADDR_WIDTH  dump read address
  dump_ack_i  in  1  dump read complete, dump_data_i valid
  dump_data_i  in  DATA_WIDTH  dump read data
  out_valid_o  out  1  output word valid
  out_ready_i  in  1  output consumer ready
  out_data_o  out  DATA_WIDTH  output word
  out_last_o  out  1  final dump word
  busy_o  out  1  state not IDLE and not DONE
  done_o  out  1  state DONE
  status_o  out  2  00 none, 01 halted, 10 budget expired, 11 aborted
  cycle_count_o  out  CNT_WIDTH  CPU cycles executed in last or current run

Function
REQ-008 SHALL implement states IDLE, RESET, RUN, DUMP_REG, DUMP_MEM, DONE.
REQ-009 IDLE/DONE: start_i=1 SHALL latch cycles_i, clear cycle_count_o and status_o, enter RESET next cycle; start_i SHALL be ignored in other states.
REQ-010 RESET: cpu_reset_no=0 for exactly RESET_CYCLES clocks, then enter RUN; cpu_reset_no=1 in every other state.
REQ-011 RUN: cpu_en_o=1 only in RUN; cycle_count_o increments by 1 per RUN cycle, saturating at 2^CNT_WIDTH-1.
REQ-012 RUN exit: cpu_halt_i=1 -> status 01; else budget nonzero and count reaching budget -> status 10; halt wins if both in same cycle; next state DUMP_REG (DUMP_MEM if REG_COUNT=0).
REQ-013 Budget B SHALL yield exactly B cycles with cpu_en_o=1; budget 0 SHALL run until halt or abort.
REQ-014 Dump: per word, dump_req_o asserted with sel/addr held stable until dump_ack_i; data captured on ack; dump_req_o deasserted the cycle after ack; one request outstanding at most.
REQ-015 Captured word SHALL appear on out_data_o with out_valid_o=1, held stable until out_valid_o & out_ready_i; next request issues the cycle after transfer.
REQ-016 DUMP_REG addresses 0..REG_COUNT-1 (sel 0), then DUMP_MEM addresses 0..MEM_DUMP_DEPTH-1 (sel 1), ascending.
REQ-017 out_last_o=1 only with the final dump word; after its transfer enter DONE.
REQ-018 abort_i=1 in RESET/RUN/DUMP_* SHALL enter DONE next cycle with status 11, dropping dump_req_o and out_valid_o; abort beats halt/budget and start in same cycle; abort ignored in IDLE/DONE.
REQ-019 dump_ack_i without outstanding request SHALL be ignored.

Reset
REQ-020 reset_ni=0 at a rising edge SHALL force IDLE in any state, including mid-run and mid-handshake.
REQ-021 Reset values: cpu_reset_no=1, cpu_en_o=0, dump_req_o=0, dump_sel_o=0, dump_addr_o=0, out_valid_o=0, out_last_o=0, out_data_o=0, busy_o=0, done_o=0, status_o=00, cycle_count_o=0, latched budget=0.

Configuration
REQ-022 Macro RUN_CTRL_MEM_DUMP_EN defined: DUMP_MEM phase present per REQ-016.
REQ-023 Macro undefined: DUMP_MEM omitted, dump_sel_o tied 0, out_last_o on final register word, DONE follows it; MEM_DUMP_DEPTH unused.

Verification
REQ-024 Reset then start, cycles_i=10, halt never -> cpu_reset_no low 2 clocks, cpu_en_o high exactly 10 clocks, status 10, cycle_count_o=10.
REQ-025 cycles_i=0, cpu_halt_i rises on 7th RUN cycle -> status 01, cycle_count_o=7, 8 reg + 15 mem words out in address order, out_last_o on mem[14].
REQ-026 out_ready_i toggling 1-of-3 cycles, dump_ack 2 cycles after request -> out_data_o stable while stalled, no word lost or duplicated, 23 transfers.
REQ-027 abort_i in RUN cycle 4 together with cpu_halt_i and start_i -> DONE next cycle, status 11, no dump activity.
REQ-028 reset_ni low during DUMP_MEM with dump_req_o high -> all outputs at REQ-021 values next cycle; new start runs normally.
REQ-029 Build without RUN_CTRL_MEM_DUMP_EN, halt after 3 cycles -> 8 words, out_last_o on reg[7], dump_sel_o never 1.
